// File: rtl/fifo_prefill_param_if.sv
// Bundle of the FIFO data, handshake and status signals.
// The master side is the user that pushes and pops; the slave side is the FIFO.
// Clock and reset are kept as plain ports on the FIFO itself.
interface fifo_prefill_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 4
);

  // Requests into the FIFO
  logic [DATA_WIDTH-1:0] i_item;
  logic                  i_write;
  logic                  i_read;
  logic                  i_clear_err;

  // Head data and status out of the FIFO
  logic [DATA_WIDTH-1:0] o_item;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overrun;
  logic                  underrun;

  modport master (
    output i_item, i_write, i_read, i_clear_err,
    input  o_item, o_count, empty, full, almost_empty, almost_full,
           overrun, underrun
  );

  modport slave (
    input  i_item, i_write, i_read, i_clear_err,
    output o_item, o_count, empty, full, almost_empty, almost_full,
           overrun, underrun
  );

endinterface

// File: rtl/fifo_prefill_param.sv
// First-word-fall-through FIFO with zero-valued prefill entries at reset.
// Used between merger-tree stages: the prefill zeros act as sentinels that
// are consumed before real items. Tracks occupancy, exposes programmable
// almost-full/almost-empty thresholds and sticky overrun/underrun flags.
// The interface instance must be built with the same DATA_WIDTH and
// DEPTH_LOG2 as this module.
module fifo_prefill_param #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 0,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
  parameter int AE_THRESH  = 1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  fifo_prefill_param_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  // Write pointer starts just past the prefilled entries
  localparam logic [DEPTH_LOG2-1:0] WR_PTR_RST = DEPTH_LOG2'(PREFILL % DEPTH);
  localparam logic [CNT_W-1:0]      CNT_RST    = CNT_W'(PREFILL);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      AF_LVL     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]      AE_LVL     = CNT_W'(AE_THRESH);

  // Zero flags set for entries 0..PREFILL-1 at reset
  function automatic logic [DEPTH-1:0] zflag_init();
    logic [DEPTH-1:0] z;
    z = '0;
    for (int i = 0; i < DEPTH; i++) begin
      z[i] = (i < PREFILL);
    end
    return z;
  endfunction

  localparam logic [DEPTH-1:0] ZFLAG_RST = zflag_init();

  // Configuration sanity checks, reported at elaboration
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("fifo_prefill_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH_LOG2 < 1) begin : g_bad_depth
    $error("fifo_prefill_param: DEPTH_LOG2 must be >= 1");
  end
  if (PREFILL < 0 || PREFILL > DEPTH) begin : g_bad_prefill
    $error("fifo_prefill_param: PREFILL must be in 0..DEPTH");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_prefill_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_prefill_param: AE_THRESH must be in 0..DEPTH-1");
  end

  // Storage; data is never reset, validity comes from count and zero flags
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Control state
  logic [DEPTH_LOG2-1:0] rd_ptr_q,  rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic [DEPTH-1:0]      zflag_q,   zflag_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  // Handshake decode
  logic empty_w;
  logic full_w;
  logic rd_ok;
  logic wr_ok;
  logic mem_we;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);

  // A pop frees the slot a push into a full FIFO needs; an empty FIFO
  // cannot bypass a same-cycle push to the reader.
  assign rd_ok  = bus.i_read && !empty_w;
  assign wr_ok  = bus.i_write && (!full_w || rd_ok);
  assign mem_we = wr_ok && !i_rst;

  // Next-state for pointers, occupancy, zero flags and sticky errors
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    zflag_d    = zflag_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (wr_ok) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      zflag_d[wr_ptr_q] = 1'b0;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first, then a new error in the same cycle sets it again
    if (bus.i_clear_err) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (bus.i_write && !wr_ok) begin
      overrun_d = 1'b1;
    end
    if (bus.i_read && !rd_ok) begin
      underrun_d = 1'b1;
    end
  end

  // Control registers, restored to the prefill state by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= WR_PTR_RST;
      count_q    <= CNT_RST;
      zflag_q    <= ZFLAG_RST;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      zflag_q    <= zflag_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Data storage write; suppressed while reset is held
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.i_item;
    end
  end

  // Head entry falls through; prefill sentinels and an empty FIFO read as 0
  always_comb begin
    bus.o_item = '0;
    if (!empty_w && !zflag_q[rd_ptr_q]) begin
      bus.o_item = mem_q[rd_ptr_q];
    end
  end

  assign bus.o_count      = count_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.overrun      = overrun_q;
  assign bus.underrun     = underrun_q;

endmodule
